// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and the shared memory port.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (F) and data traffic (D), D has priority.
// Optional macro MEM_PORT_ARB_STARVE_EN adds a starvation guard forcing F after STARVE_MAX D grants.
module mem_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_chk
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..15");
    end

    state_t            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic              grant_f, grant_d, done, force_f;
    logic              owner_d_q, we_q, mem_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              f_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0] f_rdata_q, d_rdata_q;

`ifdef MEM_PORT_ARB_STARVE_EN
    logic [3:0] starve_q;

    assign force_f = bus.f_req && (starve_q == STARVE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (grant_f) begin
            starve_q <= '0;
        end else if (grant_d && bus.f_req && (starve_q < STARVE_LIM)) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    assign force_f = 1'b0;
`endif

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        grant_f = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    if (force_f)        grant_f = 1'b1;
                    else if (bus.d_req) grant_d = 1'b1;
                    else if (bus.f_req) grant_f = 1'b1;
                end
                if (grant_f || grant_d) begin
                    state_d = ACCESS;
                    lat_d   = LAT_LOAD;
                end
            end
            ACCESS: begin
                if (lat_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            owner_d_q  <= 1'b0;
            we_q       <= 1'b0;
            mem_en_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            mem_en_q   <= grant_f || grant_d;
            f_rvalid_q <= done && !owner_d_q;
            d_rvalid_q <= done && owner_d_q;
            if (grant_f || grant_d) begin
                owner_d_q <= grant_d;
                we_q      <= grant_d && bus.d_we;
                addr_q    <= grant_d ? bus.d_addr : bus.f_addr;
                wdata_q   <= grant_d ? bus.d_wdata : '0;
            end
            if (done && !owner_d_q)
                f_rdata_q <= bus.mem_rdata;
            if (done && owner_d_q && !we_q)
                d_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.f_gnt     = grant_f;
    assign bus.d_gnt     = grant_d;
    assign bus.f_rvalid  = f_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_en_q && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q == ACCESS);
endmodule
